// File: rtl/mem_wr_arbiter.sv
// rtl/mem_wr_arbiter.sv - arbitrates loader bursts and core stores onto one register-bank write port
module mem_wr_arbiter #(
    parameter int REG_WIDTH  = 32,
    parameter int NUM_MEM    = 5,
    parameter int MEM_SELECT = $clog2(NUM_MEM),
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_ld_valid,
    output logic                  o_ld_ready,
    input  logic [MEM_SELECT-1:0] i_ld_select,
    input  logic [REG_WIDTH-1:0]  i_ld_word,
    input  logic                  i_ld_last,
    input  logic                  i_core_valid,
    output logic                  o_core_ready,
    input  logic [MEM_SELECT-1:0] i_core_select,
    input  logic [REG_WIDTH-1:0]  i_core_word,
    output logic                  o_write_enable,
    output logic [MEM_SELECT-1:0] o_write_select,
    output logic [REG_WIDTH-1:0]  o_write_data,
    output logic                  o_ld_owner,
    output logic                  o_err_addr
);
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [MEM_SELECT:0] MEM_LIMIT = (MEM_SELECT + 1)'(NUM_MEM);
    localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(BURST_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOADER,
        S_CORE
    } state_t;

    state_t                state;
    logic                  last_grant_core;
    logic [CNT_W-1:0]      beat_cnt;

    logic                  ld_xfer;
    logic                  core_xfer;
    logic                  xfer;
    logic                  burst_end;
    logic                  in_range;
    logic [MEM_SELECT-1:0] xfer_select;
    logic [REG_WIDTH-1:0]  xfer_word;

    // Readies come straight from the state register, never from valid.
    assign o_ld_ready   = (state == S_LOADER);
    assign o_core_ready = (state == S_CORE);
    assign o_ld_owner   = (state == S_LOADER);

    assign ld_xfer     = i_ld_valid && (state == S_LOADER);
    assign core_xfer   = i_core_valid && (state == S_CORE);
    assign xfer        = ld_xfer || core_xfer;
    assign burst_end   = ld_xfer && (i_ld_last || (beat_cnt == LAST_BEAT));
    assign xfer_select = ld_xfer ? i_ld_select : i_core_select;
    assign xfer_word   = ld_xfer ? i_ld_word : i_core_word;
    assign in_range    = ({1'b0, xfer_select} < MEM_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            last_grant_core <= 1'b0;
            beat_cnt        <= '0;
            o_write_enable  <= 1'b0;
            o_write_select  <= '0;
            o_write_data    <= '0;
            o_err_addr      <= 1'b0;
        end else begin
            o_write_enable <= xfer && in_range;
            if (xfer && in_range) begin
                o_write_select <= xfer_select;
                o_write_data   <= xfer_word;
            end
            if (xfer && !in_range) begin
                o_err_addr <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    // On a tie, grant whoever did not own the port last.
                    if (i_ld_valid && (!i_core_valid || last_grant_core)) begin
                        state           <= S_LOADER;
                        last_grant_core <= 1'b0;
                        beat_cnt        <= '0;
                    end else if (i_core_valid) begin
                        state           <= S_CORE;
                        last_grant_core <= 1'b1;
                    end
                end
                S_LOADER: begin
                    if (ld_xfer) begin
                        if (burst_end) begin
                            beat_cnt <= '0;
                            if (i_core_valid) begin
                                state           <= S_CORE;
                                last_grant_core <= 1'b1;
                            end else if (!i_ld_valid) begin
                                state <= S_IDLE;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end else if (i_core_valid) begin
                        state           <= S_CORE;
                        last_grant_core <= 1'b1;
                        beat_cnt        <= '0;
                    end
                end
                S_CORE: begin
                    if (i_ld_valid) begin
                        state           <= S_LOADER;
                        last_grant_core <= 1'b0;
                        beat_cnt        <= '0;
                    end else if (!i_core_valid) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_wr_arbiter.sv
// tb/tb_mem_wr_arbiter.sv - directed vector bench for mem_wr_arbiter
module tb_mem_wr_arbiter;
    logic        clk;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  ld_select;
    logic [31:0] ld_word;
    logic        ld_last;
    logic        core_valid;
    logic        core_ready;
    logic [2:0]  core_select;
    logic [31:0] core_word;
    logic        write_enable;
    logic [2:0]  write_select;
    logic [31:0] write_data;
    logic        ld_owner;
    logic        err_addr;

    int compared;
    int mismatched;

    mem_wr_arbiter #(
        .REG_WIDTH (32),
        .NUM_MEM   (5),
        .BURST_MAX (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_ld_valid     (ld_valid),
        .o_ld_ready     (ld_ready),
        .i_ld_select    (ld_select),
        .i_ld_word      (ld_word),
        .i_ld_last      (ld_last),
        .i_core_valid   (core_valid),
        .o_core_ready   (core_ready),
        .i_core_select  (core_select),
        .i_core_word    (core_word),
        .o_write_enable (write_enable),
        .o_write_select (write_select),
        .o_write_data   (write_data),
        .o_ld_owner     (ld_owner),
        .o_err_addr     (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ld_v;
        logic [2:0]  ld_sel;
        logic [31:0] ld_w;
        logic        ld_l;
        logic        c_v;
        logic [2:0]  c_sel;
        logic [31:0] c_w;
        logic        e_ldr;
        logic        e_cr;
        logic        e_we;
        logic [2:0]  e_sel;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(logic rst, logic ld_v, logic [2:0] ld_sel, logic [31:0] ld_w,
                                logic ld_l, logic c_v, logic [2:0] c_sel, logic [31:0] c_w,
                                logic e_ldr, logic e_cr, logic e_we, logic [2:0] e_sel,
                                logic [31:0] e_data, logic e_err);
        vec_t v;
        v.rst = rst; v.ld_v = ld_v; v.ld_sel = ld_sel; v.ld_w = ld_w; v.ld_l = ld_l;
        v.c_v = c_v; v.c_sel = c_sel; v.c_w = c_w;
        v.e_ldr = e_ldr; v.e_cr = e_cr; v.e_we = e_we; v.e_sel = e_sel;
        v.e_data = e_data; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ldr, input logic cr, input logic we,
                             input logic [2:0] sel, input logic [31:0] data, input logic err);
        chk({tag, ".ld_ready"},   {31'd0, ld_ready},     {31'd0, ldr});
        chk({tag, ".core_ready"}, {31'd0, core_ready},   {31'd0, cr});
        chk({tag, ".ld_owner"},   {31'd0, ld_owner},     {31'd0, ldr});
        chk({tag, ".write_en"},   {31'd0, write_enable}, {31'd0, we});
        chk({tag, ".write_sel"},  {29'd0, write_select}, {29'd0, sel});
        chk({tag, ".write_data"}, write_data,            data);
        chk({tag, ".err_addr"},   {31'd0, err_addr},     {31'd0, err});
    endtask

    task automatic drive(input logic lv, input logic [2:0] ls, input logic [31:0] lw, input logic ll,
                         input logic cv, input logic [2:0] cs, input logic [31:0] cw);
        ld_valid = lv; ld_select = ls; ld_word = lw; ld_last = ll;
        core_valid = cv; core_select = cs; core_word = cw;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
        #2 rst_n = 1'b0;
        #1 check_all("reset", 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Core only, tie handling, abandoned burst, out-of-range select.
        tbl[0]  = mk(1, 0, 0, 'h00, 0, 1, 2, 'h03, 0, 1, 0, 0, 'h00, 0);
        tbl[1]  = mk(0, 0, 0, 'h00, 0, 1, 2, 'h03, 0, 1, 1, 2, 'h03, 0);
        tbl[2]  = mk(0, 0, 0, 'h00, 0, 0, 0, 'h00, 0, 0, 0, 2, 'h03, 0);
        tbl[3]  = mk(1, 1, 1, 'h11, 0, 1, 4, 'h44, 0, 1, 0, 0, 'h00, 0);
        tbl[4]  = mk(0, 1, 1, 'h11, 0, 1, 4, 'h44, 1, 0, 1, 4, 'h44, 0);
        tbl[5]  = mk(0, 1, 1, 'h11, 1, 0, 0, 'h00, 1, 0, 1, 1, 'h11, 0);
        tbl[6]  = mk(0, 0, 0, 'h00, 0, 1, 3, 'h33, 0, 1, 0, 1, 'h11, 0);
        tbl[7]  = mk(0, 0, 0, 'h00, 0, 0, 0, 'h00, 0, 0, 0, 1, 'h11, 0);
        tbl[8]  = mk(0, 1, 0, 'h5a, 0, 1, 3, 'h33, 1, 0, 0, 1, 'h11, 0);
        tbl[9]  = mk(0, 1, 0, 'h5a, 0, 0, 0, 'h00, 1, 0, 1, 0, 'h5a, 0);
        tbl[10] = mk(0, 0, 0, 'h00, 0, 1, 7, 'h77, 0, 1, 0, 0, 'h5a, 0);
        tbl[11] = mk(0, 0, 0, 'h00, 0, 1, 7, 'h77, 0, 1, 0, 0, 'h5a, 1);
        tbl[12] = mk(0, 0, 0, 'h00, 0, 1, 2, 'h22, 0, 1, 1, 2, 'h22, 1);
        tbl[13] = mk(0, 0, 0, 'h00, 0, 0, 0, 'h00, 0, 0, 0, 2, 'h22, 1);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i].ld_v, tbl[i].ld_sel, tbl[i].ld_w, tbl[i].ld_l,
                  tbl[i].c_v, tbl[i].c_sel, tbl[i].c_w);
            step();
            check_all($sformatf("row%0d", i), tbl[i].e_ldr, tbl[i].e_cr, tbl[i].e_we,
                      tbl[i].e_sel, tbl[i].e_data, tbl[i].e_err);
        end

        // Reset in the middle of a loader burst, with the error flag set.
        drive(1'b1, 3'd3, 32'hAA, 1'b0, 1'b0, 3'd0, 32'd0);
        step();
        check_all("mid.grant", 1'b1, 1'b0, 1'b0, 3'd2, 32'h22, 1'b1);
        step();
        check_all("mid.beat", 1'b1, 1'b0, 1'b1, 3'd3, 32'hAA, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_all("mid.async", 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_all("mid.release", 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);

        // Eight back-to-back loader beats, never last; core asks from beat 6.
        do_reset();
        drive(1'b1, 3'd0, 32'h100, 1'b0, 1'b0, 3'd0, 32'd0);
        step();
        check_all("burst.grant", 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i % 5), 32'h100 + 32'(i), 1'b0, (i >= 6), 3'd4, 32'hCC);
            step();
            check_all($sformatf("burst.beat%0d", i), (i != 7), (i == 7), 1'b1,
                      3'(i % 5), 32'h100 + 32'(i), 1'b0);
        end
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 3'd4, 32'hCC);
        step();
        check_all("burst.core", 1'b0, 1'b1, 1'b1, 3'd4, 32'hCC, 1'b0);

        // Burst cut short by ld_last while the core is waiting.
        do_reset();
        drive(1'b1, 3'd1, 32'h200, 1'b0, 1'b0, 3'd0, 32'd0);
        step();
        check_all("last.grant", 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        drive(1'b1, 3'd1, 32'h200, 1'b0, 1'b1, 3'd3, 32'h300);
        step();
        check_all("last.beat0", 1'b1, 1'b0, 1'b1, 3'd1, 32'h200, 1'b0);
        drive(1'b1, 3'd2, 32'h201, 1'b1, 1'b1, 3'd3, 32'h300);
        step();
        check_all("last.beat1", 1'b0, 1'b1, 1'b1, 3'd2, 32'h201, 1'b0);
        drive(1'b1, 3'd0, 32'h202, 1'b0, 1'b1, 3'd3, 32'h300);
        step();
        check_all("last.core", 1'b1, 1'b0, 1'b1, 3'd3, 32'h300, 1'b0);
        drive(1'b1, 3'd0, 32'h202, 1'b0, 1'b0, 3'd0, 32'd0);
        step();
        check_all("last.resume", 1'b1, 1'b0, 1'b1, 3'd0, 32'h202, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
